// File: rtl/i2c_sample_packer_if.sv
// Sensor-capture and byte-stream signals of the sample packer.
// slave = packer side, master = sensor/consumer side.
interface i2c_sample_packer_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
);
  logic [23:0]            timestamp;
  logic [DATA_W-1:0]      sample_data;
  logic                   sample_valid;
  logic [7:0]             byte_out;
  logic                   byte_valid;
  logic                   byte_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;
  logic                   busy;

  modport slave (
    input  timestamp, sample_data, sample_valid, byte_ready,
    output byte_out, byte_valid, fifo_count, overflow, busy
  );

  modport master (
    output timestamp, sample_data, sample_valid, byte_ready,
    input  byte_out, byte_valid, fifo_count, overflow, busy
  );
endinterface

// File: rtl/i2c_sample_packer.sv
// Buffers {timestamp, sample} records and streams them as framed bytes.
// Optional trailing XOR checksum byte: define PACKER_CHECKSUM_EN.
module i2c_sample_packer #(
  parameter int          DATA_W    = 16,
  parameter int          DEPTH     = 16,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input logic            clk,
  input logic            rst,
  i2c_sample_packer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NB = DATA_W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int RW = 24 + DATA_W;

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_TS2, S_TS1, S_TS0, S_DATA, S_CSUM
  } state_t;

  state_t            r_state;
  logic [RW-1:0]     r_mem [DEPTH];
  logic [RW-1:0]     r_hold;
  logic [AW-1:0]     r_wp;
  logic [AW-1:0]     r_rp;
  logic [CW-1:0]     r_count;
  logic [BW-1:0]     r_bcnt;
  logic [7:0]        r_byte;
  logic              r_valid;
  logic              r_ovf;
`ifdef PACKER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_full;
  logic              w_wr;
  logic              w_acc;
  logic              w_last;
  logic              w_end;
  logic              w_pop;
  logic [BW-1:0]     w_bnext;
  logic [DATA_W-1:0] w_dsh;

  // Fullness uses the pre-pop count, so a write at full is dropped.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_wr    = bus.sample_valid && !w_full;
  assign w_acc   = r_valid && bus.byte_ready;
  assign w_last  = (r_state == S_DATA) && (r_bcnt == BW'(NB - 1));
`ifdef PACKER_CHECKSUM_EN
  assign w_end   = w_acc && (r_state == S_CSUM);
`else
  assign w_end   = w_acc && w_last;
`endif
  assign w_pop   = (r_count != '0) && ((r_state == S_IDLE) || w_end);
  assign w_bnext = r_bcnt + 1'b1;
  assign w_dsh   = r_hold[DATA_W-1:0] << (8 * w_bnext);

  assign bus.byte_out   = r_byte;
  assign bus.byte_valid = r_valid;
  assign bus.fifo_count = r_count;
  assign bus.overflow   = r_ovf;
  assign bus.busy       = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= {bus.timestamp, bus.sample_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_bcnt  <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef PACKER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (bus.sample_valid && w_full) r_ovf <= 1'b1;
      if (w_wr && !w_pop)
        r_count <= r_count + 1'b1;
      else if (!w_wr && w_pop)
        r_count <= r_count - 1'b1;

      if (w_pop) begin
        r_rp    <= r_rp + 1'b1;
        r_hold  <= r_mem[r_rp];
        r_state <= S_SYNC;
        r_byte  <= SYNC_BYTE;
        r_valid <= 1'b1;
`ifdef PACKER_CHECKSUM_EN
        r_csum  <= '0;
`endif
      end else if (w_acc) begin
`ifdef PACKER_CHECKSUM_EN
        if (r_state != S_SYNC) r_csum <= r_csum ^ r_byte;
`endif
        case (r_state)
          S_SYNC: begin
            r_state <= S_TS2;
            r_byte  <= r_hold[RW-1 -: 8];
          end
          S_TS2: begin
            r_state <= S_TS1;
            r_byte  <= r_hold[RW-9 -: 8];
          end
          S_TS1: begin
            r_state <= S_TS0;
            r_byte  <= r_hold[RW-17 -: 8];
          end
          S_TS0: begin
            r_state <= S_DATA;
            r_bcnt  <= '0;
            r_byte  <= r_hold[DATA_W-1 -: 8];
          end
          S_DATA: begin
            if (w_last) begin
`ifdef PACKER_CHECKSUM_EN
              r_state <= S_CSUM;
              r_byte  <= r_csum ^ r_byte;
`else
              r_state <= S_IDLE;
              r_byte  <= '0;
              r_valid <= 1'b0;
`endif
            end else begin
              r_bcnt <= w_bnext;
              r_byte <= w_dsh[DATA_W-1 -: 8];
            end
          end
          S_CSUM: begin
            r_state <= S_IDLE;
            r_byte  <= '0;
            r_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_sample_packer.sv
// Self-checking bench for i2c_sample_packer.
// Cycle-level queue model plus directed frame tables.
module tb_i2c_sample_packer;
  localparam int DW  = 16;
  localparam int DEP = 16;
  localparam int NB  = DW / 8;
`ifdef PACKER_CHECKSUM_EN
  localparam int FL  = 5 + NB;
`else
  localparam int FL  = 4 + NB;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_sample_packer_if #(.DATA_W(DW), .DEPTH(DEP)) bus ();

  i2c_sample_packer #(
    .DATA_W(DW), .DEPTH(DEP), .SYNC_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [39:0] m_fifo [$];
  logic [7:0]  m_frame [$];
  bit          m_ovf;
  logic [7:0]  got [$];

  typedef struct {
    logic [23:0] ts;
    logic [15:0] data;
    logic [47:0] frame;
    logic [7:0]  csum;
  } vec_t;

  vec_t vecs [4];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void load_frame(logic [39:0] rec);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    m_frame.push_back(8'hA5);
    for (int i = 0; i < 3 + NB; i++) begin
      b = rec[39 - 8*i -: 8];
      cs = cs ^ b;
      m_frame.push_back(b);
    end
`ifdef PACKER_CHECKSUM_EN
    m_frame.push_back(cs);
`endif
  endfunction

  // One clock of the model: a frame is a byte queue drained by handshakes;
  // a new record is loaded whenever no frame is left in flight.
  task automatic model_edge();
    int  pre;
    bit  wr;
    pre = m_fifo.size();
    wr  = bus.sample_valid && (pre < DEP);
    if (bus.sample_valid && !wr) m_ovf = 1'b1;
    if (m_frame.size() > 0 && bus.byte_ready) void'(m_frame.pop_front());
    if (m_frame.size() == 0 && pre > 0) load_frame(m_fifo.pop_front());
    if (wr) m_fifo.push_back({bus.timestamp, bus.sample_data});
  endtask

  task automatic compare();
    check("byte_valid", 32'(bus.byte_valid), 32'(m_frame.size() > 0));
    check("busy", 32'(bus.busy), 32'(m_frame.size() > 0));
    check("fifo_count", 32'(bus.fifo_count), 32'(m_fifo.size()));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (m_frame.size() > 0)
      check("byte_out", 32'(bus.byte_out), 32'(m_frame[0]));
  endtask

  task automatic step();
    if (bus.byte_valid && bus.byte_ready) got.push_back(bus.byte_out);
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    m_fifo.delete();
    m_frame.delete();
    m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain(int budget);
    int k;
    k = 0;
    while ((bus.byte_valid || bus.fifo_count != 0) && k < budget) begin
      step();
      k++;
    end
    check("drain_timeout", 32'(k < budget), 32'd1);
  endtask

  task automatic one_sample(logic [23:0] ts, logic [15:0] d);
    bus.timestamp    = ts;
    bus.sample_data  = d;
    bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
  endtask

  task automatic check_got(vec_t v, string nm);
    check({nm, "_len"}, 32'(got.size()), 32'(FL));
    for (int i = 0; i < FL && i < got.size(); i++) begin
      if (i < 4 + NB)
        check({nm, "_byte"}, 32'(got[i]), 32'(v.frame[47 - 8*i -: 8]));
      else
        check({nm, "_csum"}, 32'(got[i]), 32'(v.csum));
    end
  endtask

  initial begin
    int maxc;
    int k;
    vecs[0] = '{24'h123456, 16'hBEEF, 48'hA5123456BEEF, 8'h21};
    vecs[1] = '{24'h000000, 16'h0000, 48'hA50000000000, 8'h00};
    vecs[2] = '{24'hFFFFFF, 16'hFFFF, 48'hA5FFFFFFFFFF, 8'hFF};
    vecs[3] = '{24'hABCDEF, 16'h0102, 48'hA5ABCDEF0102, 8'h8A};

    rst = 1'b1;
    bus.timestamp    = '0;
    bus.sample_data  = '0;
    bus.sample_valid = 1'b0;
    bus.byte_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_byte_out", 32'(bus.byte_out), 32'd0);
    check("rst_byte_valid", 32'(bus.byte_valid), 32'd0);
    check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    do_reset();

    // Table of single frames with the sink always ready.
    bus.byte_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      got.delete();
      one_sample(vecs[v].ts, vecs[v].data);
      check("lat_count", 32'(bus.fifo_count), 32'd1);
      check("lat_valid0", 32'(bus.byte_valid), 32'd0);
      step();
      check("lat_valid1", 32'(bus.byte_valid), 32'd1);
      check("lat_sync", 32'(bus.byte_out), 32'hA5);
      drain(40);
      check_got(vecs[v], "table");
      check("idle_busy", 32'(bus.busy), 32'd0);
    end

    // Backpressure pattern 1,0,0,1,0,0,...
    got.delete();
    one_sample(vecs[0].ts, vecs[0].data);
    k = 0;
    while ((bus.byte_valid || bus.fifo_count != 0) && k < 100) begin
      bus.byte_ready = (k % 3 == 0);
      step();
      k++;
    end
    check("bp_timeout", 32'(k < 100), 32'd1);
    check_got(vecs[0], "bp");
    bus.byte_ready = 1'b1;

    // Fill to full with the sink stalled, then pop at full with a write.
    do_reset();
    bus.byte_ready = 1'b0;
    for (int i = 0; i < 18; i++) one_sample(24'h000100 + 24'(i), 16'(i));
    check("full_count", 32'(bus.fifo_count), 32'(DEP));
    check("full_ovf", 32'(bus.overflow), 32'd1);
    check("full_sync", 32'(bus.byte_out), 32'hA5);
    bus.byte_ready = 1'b1;
    repeat (FL - 1) step();
    one_sample(24'hFACE00, 16'h9999);
    check("simul_count", 32'(bus.fifo_count), 32'(DEP - 1));
    drain(400);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Slow producer: pointers wrap, count stays at most 1.
    do_reset();
    bus.byte_ready = 1'b1;
    got.delete();
    maxc = 0;
    for (int i = 0; i < 40; i++) begin
      one_sample(24'(i * 24'h010203), 16'($urandom));
      for (int j = 0; j < FL + 2; j++) begin
        if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
        step();
      end
    end
    check("wrap_maxcount", 32'(maxc <= 1), 32'd1);
    check("wrap_bytes", 32'(got.size()), 32'(40 * FL));

    // Reset mid-frame after TS1 is accepted.
    do_reset();
    bus.byte_ready = 1'b1;
    one_sample(24'h123456, 16'hBEEF);
    repeat (4) step();
    rst = 1'b1;
    #1;
    check("mid_byte_out", 32'(bus.byte_out), 32'd0);
    check("mid_valid", 32'(bus.byte_valid), 32'd0);
    check("mid_count", 32'(bus.fifo_count), 32'd0);
    check("mid_ovf", 32'(bus.overflow), 32'd0);
    check("mid_busy", 32'(bus.busy), 32'd0);
    do_reset();
    got.delete();
    one_sample(vecs[3].ts, vecs[3].data);
    drain(40);
    check_got(vecs[3], "post_rst");

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bus.timestamp    = 24'($urandom);
      bus.sample_data  = 16'($urandom);
      bus.sample_valid = ($urandom_range(0, 4) == 0);
      bus.byte_ready   = ($urandom_range(0, 3) != 0);
      step();
    end
    bus.sample_valid = 1'b0;
    bus.byte_ready   = 1'b1;
    drain(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
